dbg_mem_bridge: RTL and testbench
=================================

Name: dbg_mem_bridge

Overview:
- Responder side of the debug monitor's memory interface.
- Services the monitor's address, write-data and read-data handshake against the IMEM/DMEM debug port.
- Uses a req/ack memory handshake with timeout.
- Keeps `data_in_valid` coherent with the current address and memory space, and stretches write-complete long enough for a command processor that re-pulses `data_out_ready`.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles waiting for `mem_ack` before forcing completion; must be at least 1
- TIMEOUT_DATA, 32'hDEADBEEF, value returned on `data_in` for a timed-out read

Ports:
- clk  in  1  clock
- rst_p  in  1  synchronous, active-high reset
- addr  in  32  monitor address; byte address, word-aligned access
- data_out  in  32  monitor write data
- data_out_ready  in  1  monitor write request; may toggle 1/0/1 while the monitor waits
- data_imem_p_dmem_n  in  1  space select, 1 = IMEM, 0 = DMEM
- data_in  out  32  read data
- data_in_valid  out  1  `data_in` reflects mem[addr] in the selected space
- data_write_complete  out  1  write done; held high, see Behaviour
- cpu_halted  in  1  CPU stopped; memory requests are issued only while high
- mem_req  out  1  request to the memory debug port
- mem_we  out  1  1 = write, 0 = read; valid with `mem_req`
- mem_imem_sel  out  1  space for the current request
- mem_addr  out  32  request address
- mem_wdata  out  32  request write data
- mem_rdata  in  32  read return; valid with `mem_ack`
- mem_ack  in  1  one-cycle completion pulse
- timeout_err  out  1  sticky; set on any timeout; cleared only by reset

Behaviour:
- Reset: `rst_p` is sampled on the `clk` edge.
  - All outputs are 0; `data_in` = 0.
  - State is IDLE and the tag is invalid.
  - Reset mid-transaction abandons the transaction: `mem_req` drops the next cycle and a late `mem_ack` is ignored.
- Tag register: latches {addr, space} of the last completed read.
  - `data_in_valid` = tag_valid AND tag == {addr, data_imem_p_dmem_n}, registered.
  - Any change of `addr` or space drops `data_in_valid` on the next cycle.
- States:
  - IDLE → WR_REQ when a `data_out_ready` rising edge (0→1) is seen and `cpu_halted`=1.
  - Otherwise IDLE → RD_REQ when the tag mismatches and `cpu_halted`=1.
  - Write takes priority when both conditions hold in the same cycle.
  - Entering RD_REQ or WR_REQ registers `mem_addr`, `mem_wdata` and `mem_imem_sel`, and raises `mem_req`.
- RD_REQ:
  - `mem_req`=1 and `mem_we`=0 until `mem_ack`.
  - On `mem_ack`: `data_in` ← `mem_rdata`, tag ← request {addr, space}, tag_valid=1, return to IDLE.
  - If addr/space changed during the request, the tag mismatches and a new read follows automatically.
- WR_REQ:
  - `mem_req`=1 and `mem_we`=1 until `mem_ack`.
  - Then go to WR_DONE and invalidate the tag if it equals the written {addr, space}.
- WR_DONE:
  - `data_write_complete`=1.
  - `data_out_ready` pulses arriving here are ignored and never start a second write.
  - Exit to IDLE after `data_out_ready`=0 for 2 consecutive cycles; `data_write_complete` drops on the exit cycle.
- Timeout:
  - A counter runs in RD_REQ/WR_REQ.
  - Reaching TIMEOUT_CYCLES without `mem_ack` forces completion and sets `timeout_err`.
  - A timed-out read loads `data_in`=TIMEOUT_DATA with tag valid.
  - A timed-out write enters WR_DONE normally.
- `cpu_halted`=0: no requests are issued.
  - A `data_out_ready` edge seen while not halted is remembered (pending bit) and serviced once halted.
  - `cpu_halted` falling mid-request does not abort the request.
- `mem_ack` outside RD_REQ/WR_REQ is ignored.
- Latency: addr change → `data_in_valid`=1 in 2 + memory latency cycles (ack on the first request cycle gives 3).

Decomposition:
- Shared package holds: state encoding (IDLE, RD_REQ, WR_REQ, WR_DONE), the TIMEOUT_DATA default, and the IMEM/DMEM select constants.
- One natural sub-module, `dbg_req_timer`: a loadable down-counter with an expire flag, reused by any future debug-port bridge.

Test Plan:
- Halted; addr=0x00000010, DMEM; memory acks after 3 cycles with 0x12345678 → `data_in`=0x12345678, `data_in_valid`=1; addr→0x14 drops valid next cycle.
- `data_out_ready` toggling 1/0/1/0 for 10 cycles with `data_out`=0xCAFEF00D at 0x20 → exactly one `mem_req` with `mem_we`=1, `mem_wdata`=0xCAFEF00D; `data_write_complete` held through the toggling and cleared 2 cycles after the toggling stops.
- Read 0x20 valid, then write 0x20 → valid drops, a fresh read is issued, new data is returned.
- No `mem_ack`, TIMEOUT_CYCLES=8 → completion at cycle 8, `data_in`=0xDEADBEEF, `timeout_err`=1 (sticky).
- `cpu_halted`=0 with a write edge → no `mem_req`; raise `cpu_halted` → write serviced.
- `rst_p` during RD_REQ with ack arriving after reset → all outputs 0, ack ignored, valid stays 0 until a new read completes.

Source files
------------

// File: rtl/dbg_mem_bridge_pkg.sv
// Shared types and constants for the debug-monitor memory bridge.
// Covers the FSM state encoding, the IMEM/DMEM select values and the read-tag record.
package dbg_mem_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_REQ  = 2'd1,
    ST_WR_REQ  = 2'd2,
    ST_WR_DONE = 2'd3
  } bridge_state_e;

  localparam logic [31:0] TIMEOUT_DATA_DEFAULT = 32'hDEAD_BEEF;
  localparam logic        SEL_IMEM             = 1'b1;
  localparam logic        SEL_DMEM             = 1'b0;

  typedef struct packed {
    logic        imem;
    logic [31:0] addr;
  } mem_tag_t;

  // True when a valid tag names the same word in the same space.
  function automatic logic tag_hit(input logic valid, input mem_tag_t tag, input mem_tag_t probe);
    return valid && (tag == probe);
  endfunction

endpackage

// File: rtl/dbg_req_timer.sv
// Loadable down-counter with an expire flag, used to bound how long a
// debug-port request may wait for its acknowledge.
module dbg_req_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_p,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  logic [WIDTH-1:0] count_r;

  // Load wins; otherwise count down while enabled and saturate at zero.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      count_r <= {WIDTH{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (enable && (count_r != {WIDTH{1'b0}})) begin
      count_r <= count_r - WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = enable && (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/dbg_mem_bridge.sv
// Responder for the debug monitor's memory interface: turns address changes and
// write strobes into req/ack transactions on the IMEM/DMEM debug port.
module dbg_mem_bridge
  import dbg_mem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = TIMEOUT_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_p,
  input  logic [31:0] addr,
  input  logic [31:0] data_out,
  input  logic        data_out_ready,
  input  logic        data_imem_p_dmem_n,
  output logic [31:0] data_in,
  output logic        data_in_valid,
  output logic        data_write_complete,
  input  logic        cpu_halted,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_imem_sel,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        timeout_err
);

  localparam int unsigned      CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TIMER_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  bridge_state_e state_r, state_s;
  mem_tag_t      tag_r, tag_s, cur_tag_s, req_tag_s;
  logic          tag_valid_r, tag_valid_s;
  logic          dor_prev_r;
  logic          wr_pending_r, wr_pending_s;
  logic          low_seen_r, low_seen_s;
  logic          mem_req_r, mem_req_s;
  logic          mem_we_r, mem_we_s;
  logic          mem_imem_sel_r, mem_imem_sel_s;
  logic [31:0]   mem_addr_r, mem_addr_s;
  logic [31:0]   mem_wdata_r, mem_wdata_s;
  logic [31:0]   data_in_r, data_in_s;
  logic          data_in_valid_r, data_in_valid_s;
  logic          wr_complete_r, wr_complete_s;
  logic          timeout_err_r, timeout_err_s;
  logic          rise_s, hit_s, done_s, req_active_s;
  logic          timer_load_s, timer_expired_s;

  assign cur_tag_s.addr = addr;
  assign cur_tag_s.imem = (data_imem_p_dmem_n == SEL_IMEM);
  assign req_tag_s.addr = mem_addr_r;
  assign req_tag_s.imem = mem_imem_sel_r;

  assign rise_s       = data_out_ready && !dor_prev_r;
  assign hit_s        = tag_hit(tag_valid_r, tag_r, cur_tag_s);
  assign req_active_s = (state_r == ST_RD_REQ) || (state_r == ST_WR_REQ);
  assign done_s       = mem_ack || timer_expired_s;

  dbg_req_timer #(
    .WIDTH (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst_p      (rst_p),
    .load       (timer_load_s),
    .load_value (TIMER_LOAD),
    .enable     (req_active_s),
    .expired    (timer_expired_s)
  );

  // Next-state and next-output logic for the request FSM.
  always_comb begin
    state_s         = state_r;
    tag_s           = tag_r;
    tag_valid_s     = tag_valid_r;
    wr_pending_s    = wr_pending_r;
    low_seen_s      = low_seen_r;
    mem_req_s       = mem_req_r;
    mem_we_s        = mem_we_r;
    mem_imem_sel_s  = mem_imem_sel_r;
    mem_addr_s      = mem_addr_r;
    mem_wdata_s     = mem_wdata_r;
    data_in_s       = data_in_r;
    wr_complete_s   = wr_complete_r;
    timeout_err_s   = timeout_err_r;
    timer_load_s    = 1'b0;
    data_in_valid_s = hit_s;

    case (state_r)
      ST_IDLE: begin
        if (cpu_halted && (rise_s || wr_pending_r)) begin
          state_s        = ST_WR_REQ;
          mem_req_s      = 1'b1;
          mem_we_s       = 1'b1;
          mem_addr_s     = addr;
          mem_wdata_s    = data_out;
          mem_imem_sel_s = cur_tag_s.imem;
          wr_pending_s   = 1'b0;
          timer_load_s   = 1'b1;
        end else if (cpu_halted && !hit_s) begin
          state_s        = ST_RD_REQ;
          mem_req_s      = 1'b1;
          mem_we_s       = 1'b0;
          mem_addr_s     = addr;
          mem_wdata_s    = data_out;
          mem_imem_sel_s = cur_tag_s.imem;
          timer_load_s   = 1'b1;
        end else if (rise_s) begin
          wr_pending_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_RD_REQ: begin
        // A write strobe landing during a read is serviced right after it.
        if (rise_s) begin
          wr_pending_s = 1'b1;
        end else begin
          wr_pending_s = wr_pending_r;
        end
        if (done_s) begin
          state_s     = ST_IDLE;
          mem_req_s   = 1'b0;
          data_in_s   = mem_ack ? mem_rdata : TIMEOUT_DATA;
          tag_s       = req_tag_s;
          tag_valid_s = 1'b1;
          if (!mem_ack) begin
            timeout_err_s = 1'b1;
          end else begin
            timeout_err_s = timeout_err_r;
          end
        end else begin
          state_s = ST_RD_REQ;
        end
      end

      ST_WR_REQ: begin
        if (done_s) begin
          state_s       = ST_WR_DONE;
          mem_req_s     = 1'b0;
          mem_we_s      = 1'b0;
          wr_complete_s = 1'b1;
          low_seen_s    = 1'b0;
          if (tag_hit(tag_valid_r, tag_r, req_tag_s)) begin
            tag_valid_s = 1'b0;
          end else begin
            tag_valid_s = tag_valid_r;
          end
          if (!mem_ack) begin
            timeout_err_s = 1'b1;
          end else begin
            timeout_err_s = timeout_err_r;
          end
        end else begin
          state_s = ST_WR_REQ;
        end
      end

      ST_WR_DONE: begin
        // Hold completion until the monitor has released its strobe for two cycles.
        if (!data_out_ready) begin
          if (low_seen_r) begin
            state_s       = ST_IDLE;
            wr_complete_s = 1'b0;
            low_seen_s    = 1'b0;
          end else begin
            low_seen_s = 1'b1;
          end
        end else begin
          low_seen_s = 1'b0;
        end
      end

      default: begin
        state_s       = ST_IDLE;
        mem_req_s     = 1'b0;
        mem_we_s      = 1'b0;
        wr_complete_s = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      state_r         <= ST_IDLE;
      tag_r           <= '{imem: SEL_DMEM, addr: 32'h0000_0000};
      tag_valid_r     <= 1'b0;
      dor_prev_r      <= 1'b0;
      wr_pending_r    <= 1'b0;
      low_seen_r      <= 1'b0;
      mem_req_r       <= 1'b0;
      mem_we_r        <= 1'b0;
      mem_imem_sel_r  <= SEL_DMEM;
      mem_addr_r      <= 32'h0000_0000;
      mem_wdata_r     <= 32'h0000_0000;
      data_in_r       <= 32'h0000_0000;
      data_in_valid_r <= 1'b0;
      wr_complete_r   <= 1'b0;
      timeout_err_r   <= 1'b0;
    end else begin
      state_r         <= state_s;
      tag_r           <= tag_s;
      tag_valid_r     <= tag_valid_s;
      dor_prev_r      <= data_out_ready;
      wr_pending_r    <= wr_pending_s;
      low_seen_r      <= low_seen_s;
      mem_req_r       <= mem_req_s;
      mem_we_r        <= mem_we_s;
      mem_imem_sel_r  <= mem_imem_sel_s;
      mem_addr_r      <= mem_addr_s;
      mem_wdata_r     <= mem_wdata_s;
      data_in_r       <= data_in_s;
      data_in_valid_r <= data_in_valid_s;
      wr_complete_r   <= wr_complete_s;
      timeout_err_r   <= timeout_err_s;
    end
  end

  assign data_in             = data_in_r;
  assign data_in_valid       = data_in_valid_r;
  assign data_write_complete = wr_complete_r;
  assign mem_req             = mem_req_r;
  assign mem_we              = mem_we_r;
  assign mem_imem_sel        = mem_imem_sel_r;
  assign mem_addr            = mem_addr_r;
  assign mem_wdata           = mem_wdata_r;
  assign timeout_err         = timeout_err_r;

endmodule

// File: tb/tb_dbg_mem_bridge.sv
// Scoreboard bench for dbg_mem_bridge: stimulus pushes expected requests and read
// data, a monitor pops them as the DUT presents mem_req and data_in_valid edges.
module tb_dbg_mem_bridge;

  localparam int          TO      = 8;
  localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;

  typedef struct {
    logic        we;
    logic        sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_p;
  logic [31:0] addr, data_out, data_in, mem_addr, mem_wdata, mem_rdata;
  logic        data_out_ready, sel, data_in_valid, data_write_complete, cpu_halted;
  logic        mem_req, mem_we, mem_imem_sel, mem_ack, timeout_err;

  int          total = 0;
  int          bad   = 0;
  req_t        exp_req_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] ref_mem[logic [32:0]];
  logic [31:0] phys_mem[logic [32:0]];
  logic [32:0] cur_key;
  int          ack_lat    = 0;
  bit          no_ack     = 1'b0;
  int          inject_req = 0;

  always #5 clk = ~clk;

  dbg_mem_bridge #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk                 (clk),
    .rst_p               (rst_p),
    .addr                (addr),
    .data_out            (data_out),
    .data_out_ready      (data_out_ready),
    .data_imem_p_dmem_n  (sel),
    .data_in             (data_in),
    .data_in_valid       (data_in_valid),
    .data_write_complete (data_write_complete),
    .cpu_halted          (cpu_halted),
    .mem_req             (mem_req),
    .mem_we              (mem_we),
    .mem_imem_sel        (mem_imem_sel),
    .mem_addr            (mem_addr),
    .mem_wdata           (mem_wdata),
    .mem_rdata           (mem_rdata),
    .mem_ack             (mem_ack),
    .timeout_err         (timeout_err)
  );

  function automatic logic [31:0] dflt(input logic [32:0] k);
    return k[31:0] ^ (k[32] ? 32'hA5A5_0000 : 32'h0000_5A5A);
  endfunction

  function automatic logic [31:0] ref_val(input logic [32:0] k);
    return ref_mem.exists(k) ? ref_mem[k] : dflt(k);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory responder: acks the Nth request cycle, or injects a stray ack on demand.
  initial begin
    int rc = 0;
    int inj_done = 0;
    logic [32:0] k;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (inject_req != inj_done) begin
        inj_done  = inject_req;
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_0BAD;
        rc = 0;
      end else if (mem_req && !rst_p) begin
        rc++;
        if (!no_ack && rc == ack_lat + 1) begin
          mem_ack = 1'b1;
          k = {mem_imem_sel, mem_addr};
          if (mem_we) phys_mem[k] = mem_wdata;
          else mem_rdata = phys_mem.exists(k) ? phys_mem[k] : dflt(k);
        end
      end else begin
        rc = 0;
      end
    end
  end

  // Monitor: compares each new request and each new valid read against the queues.
  initial begin
    logic prev_req = 1'b0;
    logic prev_val = 1'b0;
    req_t e;
    logic [31:0] d;
    forever begin
      @(negedge clk);
      if (mem_req && !prev_req) begin
        if (exp_req_q.size() == 0) begin
          chk("unexpected_req", {mem_imem_sel, mem_addr[30:0]}, 32'hFFFF_FFFF);
        end else begin
          e = exp_req_q.pop_front();
          chk("req_we", 32'(mem_we), 32'(e.we));
          chk("req_addr", mem_addr, e.addr);
          chk("req_sel", 32'(mem_imem_sel), 32'(e.sel));
          if (e.we) chk("req_wdata", mem_wdata, e.wdata);
        end
      end
      if (data_in_valid && !prev_val) begin
        if (exp_rd_q.size() == 0) begin
          chk("unexpected_valid", data_in, 32'hFFFF_FFFF);
        end else begin
          d = exp_rd_q.pop_front();
          chk("rd_data", data_in, d);
        end
      end
      prev_req = mem_req;
      prev_val = data_in_valid;
    end
  end

  task automatic wait_valid(input string nm, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!data_in_valid && n < budget);
    chk(nm, 32'(data_in_valid), 32'd1);
  endtask

  task automatic do_read(input logic [31:0] a, input logic s, input int lat, input bit to);
    int n = 0;
    int reqc = 0;
    logic [32:0] k = {s, a};
    ack_lat = lat;
    no_ack  = to;
    exp_req_q.push_back('{1'b0, s, a, 32'h0});
    exp_rd_q.push_back(to ? TO_DATA : ref_val(k));
    @(negedge clk);
    addr = a; sel = s; cpu_halted = 1'b1;
    @(negedge clk);
    n = 1;
    chk("valid_drop", 32'(data_in_valid), 32'd0);
    if (mem_req) reqc++;
    while (!data_in_valid && n < 40) begin
      @(negedge clk);
      n++;
      if (mem_req) reqc++;
    end
    chk("rd_valid", 32'(data_in_valid), 32'd1);
    chk("rd_latency", 32'(n), to ? 32'(2 + TO) : 32'(3 + lat));
    chk("req_cycles", 32'(reqc), to ? 32'(TO) : 32'(lat + 1));
    if (to) chk("timeout_err_set", 32'(timeout_err), 32'd1);
    no_ack  = 1'b0;
    cur_key = k;
  endtask

  task automatic do_write(input logic [31:0] a, input logic s, input logic [31:0] d, input int lat);
    logic [32:0] k = {s, a};
    ack_lat = lat;
    exp_req_q.push_back('{1'b1, s, a, d});
    exp_req_q.push_back('{1'b0, s, a, 32'h0});
    ref_mem[k] = d;
    exp_rd_q.push_back(d);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 9) chk("wdc_during_toggle", 32'(data_write_complete), 32'd1);
      if (i == 0) begin
        addr = a; sel = s; data_out = d; cpu_halted = 1'b1;
      end
      data_out_ready = (i % 2 == 0);
    end
    @(negedge clk);
    chk("wdc_held", 32'(data_write_complete), 32'd1);
    chk("valid_after_wr", 32'(data_in_valid), 32'd0);
    @(negedge clk);
    chk("wdc_clear", 32'(data_write_complete), 32'd0);
    wait_valid("wr_readback", 20);
    cur_key = k;
  endtask

  initial begin
    logic [31:0] a, d;
    logic        s;
    logic        seen;
    int          n;
    rst_p = 1'b1; addr = 32'h0; data_out = 32'h0; data_out_ready = 1'b0;
    sel = 1'b0; cpu_halted = 1'b0;
    ref_mem[{1'b0, 32'h0000_0010}]  = 32'h1234_5678;
    phys_mem[{1'b0, 32'h0000_0010}] = 32'h1234_5678;
    repeat (3) @(negedge clk);
    chk("rst_flags", {26'h0, mem_req, mem_we, mem_imem_sel, data_in_valid, data_write_complete, timeout_err}, 32'h0);
    chk("rst_data_in", data_in, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    rst_p = 1'b0;

    do_read(32'h0000_0010, 1'b0, 2, 1'b0);
    do_read(32'h0000_0014, 1'b0, 0, 1'b0);
    do_read(32'h0000_0020, 1'b0, 1, 1'b0);
    do_write(32'h0000_0020, 1'b0, 32'hCAFE_F00D, 3);
    do_write(32'h0000_0020, 1'b0, 32'h0123_4567, 0);

    do_read(32'h0000_0030, 1'b1, 0, 1'b1);
    do_read(32'h0000_0034, 1'b1, 1, 1'b0);
    chk("timeout_sticky", 32'(timeout_err), 32'd1);

    // Write strobe while running is held until the CPU halts.
    a = 32'h0000_0040; s = 1'b0; d = $urandom;
    ack_lat = 1;
    exp_req_q.push_back('{1'b1, s, a, d});
    exp_req_q.push_back('{1'b0, s, a, 32'h0});
    ref_mem[{s, a}] = d;
    exp_rd_q.push_back(d);
    @(negedge clk);
    cpu_halted = 1'b0; addr = a; sel = s; data_out = d; data_out_ready = 1'b1;
    @(negedge clk);
    data_out_ready = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= mem_req;
    end
    chk("nohalt_req", 32'(seen), 32'd0);
    cpu_halted = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!data_write_complete && n < 20);
    chk("nohalt_wdc", 32'(data_write_complete), 32'd1);
    wait_valid("nohalt_readback", 20);
    cur_key = {s, a};

    for (int i = 0; i < 16; i++) begin
      a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      s = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) do_write(a, s, $urandom, int'($urandom_range(0, 3)));
      else if ({s, a} != cur_key) do_read(a, s, int'($urandom_range(0, 3)), 1'b0);
    end

    // Reset during a pending read; the late ack must not be taken.
    no_ack = 1'b1;
    exp_req_q.push_back('{1'b0, 1'b1, 32'h0000_0050, 32'h0});
    @(negedge clk);
    addr = 32'h0000_0050; sel = 1'b1; cpu_halted = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req && n < 10);
    chk("rst_req_seen", 32'(mem_req), 32'd1);
    rst_p = 1'b1; cpu_halted = 1'b0;
    inject_req++;
    @(negedge clk);
    chk("rst_mid_flags", {26'h0, mem_req, mem_we, mem_imem_sel, data_in_valid, data_write_complete, timeout_err}, 32'h0);
    chk("rst_mid_data_in", data_in, 32'h0);
    rst_p = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack_ignored", {31'h0, data_in_valid} | data_in, 32'h0);
    no_ack = 1'b0; ack_lat = 0;
    exp_req_q.push_back('{1'b0, 1'b1, 32'h0000_0050, 32'h0});
    exp_rd_q.push_back(ref_val({1'b1, 32'h0000_0050}));
    cpu_halted = 1'b1;
    wait_valid("rst_readback", 20);

    repeat (4) @(negedge clk);
    chk("req_q_empty", 32'(exp_req_q.size()), 32'd0);
    chk("rd_q_empty", 32'(exp_rd_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
